// File: rtl/controle_bomba_nivel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controle_bomba_nivel_pkg
// Description : Shared types and helpers for the level-driven pump controller.
//               Holds the FSM state enum, the filtered level codes and the
//               decoder that maps a probe pattern {a,m,b} to a level.
// Revision    : 1.0 - initial release
// ============================================================================
package controle_bomba_nivel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_IRRIGATE = 2'd2,
        ST_FAULT    = 2'd3
    } estado_t;

    localparam logic [1:0] c_LVL_EMPTY = 2'd0;
    localparam logic [1:0] c_LVL_LOW   = 2'd1;
    localparam logic [1:0] c_LVL_MID   = 2'd2;
    localparam logic [1:0] c_LVL_HIGH  = 2'd3;

    typedef struct packed {
        logic       valido;
        logic [1:0] nivel;
    } nivel_dec_t;

    // Probes are stacked, so a submerged probe implies every probe below it
    // is submerged too. Any pattern breaking that rule is a sensor fault.
    function automatic nivel_dec_t decodifica_nivel(input logic [2:0] abm);
        nivel_dec_t r;
        r.valido = 1'b1;
        r.nivel  = c_LVL_EMPTY;
        case (abm)
            3'b000:  r.nivel = c_LVL_EMPTY;
            3'b001:  r.nivel = c_LVL_LOW;
            3'b011:  r.nivel = c_LVL_MID;
            3'b111:  r.nivel = c_LVL_HIGH;
            default: r.valido = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filtro_sensor.sv
`default_nettype none
// ============================================================================
// Module      : filtro_sensor
// Description : Conditioning of one asynchronous level probe: 2-flop
//               synchronizer followed, when NIVEL_DEBOUNCE_EN is defined, by a
//               stability filter that accepts a new value only after
//               DEBOUNCE_CYCLES consecutive identical synchronized samples.
//               With NIVEL_DEBOUNCE_EN undefined the synchronizer output is
//               used directly and the module has no parameter.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               raw_i  - raw probe input (asynchronous)
//               filt_o - conditioned probe value
// Revision    : 1.0 - initial release
// ============================================================================
module filtro_sensor
`ifdef NIVEL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef NIVEL_DEBOUNCE_EN
    localparam logic [7:0] c_CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic       filt_q;
    logic       filt_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // cnt_q holds how many consecutive differing samples were already seen;
    // the DEBOUNCE_CYCLES-th one commits the new value.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = 8'd0;
        if (sync2_q != filt_q) begin
            if (cnt_q == c_CNT_MAX) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
`else
    assign filt_o = sync2_q;
`endif

endmodule
`default_nettype wire

// File: rtl/controle_bomba_nivel.sv
`default_nettype none
// ============================================================================
// Module      : controle_bomba_nivel
// Description : Tank level controller. Three stacked probes give a filtered
//               level; an IDLE/FILL/IRRIGATE/FAULT FSM drives the fill pump
//               and the irrigation valve, with a fill timeout watchdog.
//               Optional probe debounce is compiled in with NIVEL_DEBOUNCE_EN.
// Ports       : clk, rst_n            - clock, async active-low reset
//               sens_a/sens_m/sens_b  - high/medium/low probes (async)
//               irr_req               - irrigation request (level)
//               fault_clr             - fault acknowledge (pulse)
//               pump_on, valve_on     - actuator drives (registered)
//               alarm                 - FAULT or empty tank (registered)
//               level[1:0]            - filtered level code
//               state[1:0]            - FSM state code
// Revision    : 1.0 - initial release
// ============================================================================
module controle_bomba_nivel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FILL_TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sens_a,
    input  logic       sens_m,
    input  logic       sens_b,
    input  logic       irr_req,
    input  logic       fault_clr,
    output logic       pump_on,
    output logic       valve_on,
    output logic       alarm,
    output logic [1:0] level,
    output logic [1:0] state
);
    import controle_bomba_nivel_pkg::*;

    // Cycles needed after reset before the filtered probes reflect the
    // real inputs; the FSM stays frozen until then.
`ifdef NIVEL_DEBOUNCE_EN
    localparam int c_LAT = 2 + DEBOUNCE_CYCLES;
`else
    // DEBOUNCE_CYCLES has no effect without the stability filter.
    localparam int c_LAT = 2 + 0 * DEBOUNCE_CYCLES;
`endif
    localparam int              c_RW      = $clog2(c_LAT + 1);
    localparam logic [c_RW-1:0] c_RDY     = c_RW'(c_LAT);
    localparam int              c_TW      = $clog2(FILL_TIMEOUT);
    localparam logic [c_TW-1:0] c_TMO_LIM = c_TW'(FILL_TIMEOUT - 1);

    logic [2:0]      w_raw;
    logic [2:0]      w_filt;
    nivel_dec_t      w_dec;
    logic [1:0]      w_level;
    logic            w_ready;

    estado_t         state_q, state_d;
    logic [1:0]      level_q, level_d;
    logic [c_TW-1:0] tmo_q, tmo_d;
    logic [c_RW-1:0] rdy_cnt_q, rdy_cnt_d;
    logic            pump_q, pump_d;
    logic            valve_q, valve_d;
    logic            alarm_q, alarm_d;

    // Bit order {a,m,b} so the vector reads top probe first.
    assign w_raw = {sens_a, sens_m, sens_b};

    for (genvar i = 0; i < 3; i++) begin : g_filtro
        filtro_sensor
`ifdef NIVEL_DEBOUNCE_EN
        #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        )
`endif
        u_filtro (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_i (w_raw[i]),
            .filt_o(w_filt[i])
        );
    end

    // Level follows valid patterns and freezes on inconsistent ones.
    assign w_dec   = decodifica_nivel(w_filt);
    assign w_level = w_dec.valido ? w_dec.nivel : level_q;
    assign w_ready = (rdy_cnt_q == c_RDY);

    // Datapath next-state: startup counter, held level, fill watchdog.
    always_comb begin
        rdy_cnt_d = rdy_cnt_q;
        if (!w_ready) begin
            rdy_cnt_d = rdy_cnt_q + 1'b1;
        end
        level_d = w_level;
        // Zero outside FILL, so the count always restarts on entering FILL.
        tmo_d = '0;
        if ((state_q == ST_FILL) && !(w_level > level_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        if (w_ready) begin
            if (!w_dec.valido) begin
                state_d = ST_FAULT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_level <= c_LVL_LOW) begin
                            state_d = ST_FILL;
                        end else if (irr_req && (w_level >= c_LVL_MID)) begin
                            state_d = ST_IRRIGATE;
                        end
                    end
                    ST_FILL: begin
                        if (w_level == c_LVL_HIGH) begin
                            state_d = ST_IDLE;
                        end else if (tmo_q == c_TMO_LIM) begin
                            state_d = ST_FAULT;
                        end
                    end
                    ST_IRRIGATE: begin
                        // Low level returns to IDLE; IDLE then starts filling.
                        if (!irr_req || (w_level <= c_LVL_LOW)) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_FAULT: begin
                        if (fault_clr) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_FAULT;
                endcase
            end
        end
    end

    // FSM outputs, decoded from the next state so they align with state_q.
    always_comb begin
        pump_d  = (state_d == ST_FILL);
        valve_d = (state_d == ST_IRRIGATE);
        alarm_d = (state_d == ST_FAULT) || (w_level == c_LVL_EMPTY);
    end

    // State and output registers; async reset de-energizes actuators at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            level_q   <= c_LVL_EMPTY;
            tmo_q     <= '0;
            rdy_cnt_q <= '0;
            pump_q    <= 1'b0;
            valve_q   <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            tmo_q     <= tmo_d;
            rdy_cnt_q <= rdy_cnt_d;
            pump_q    <= pump_d;
            valve_q   <= valve_d;
            alarm_q   <= alarm_d;
        end
    end

    assign pump_on  = pump_q;
    assign valve_on = valve_q;
    assign alarm    = alarm_q;
    assign level    = w_level;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: doc/controle_bomba_nivel.md
CONTROLE_BOMBA_NIVEL -- requirements
Module: controle_bomba_nivel

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized samples needed to accept a sensor change (range 2..255).
REQ-002 Parameter FILL_TIMEOUT, default 1000: maximum cycles in FILL without a level increase before FAULT (range 2..65535).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sens_a / sens_m / sens_b  input  1 each  high / medium / low level probes, asynchronous, 1 = submerged.
REQ-006 irr_req  input  1  irrigation request, level-sensitive.
REQ-007 fault_clr  input  1  single-cycle fault acknowledge.
REQ-008 pump_on  output  1  fill pump drive.
REQ-009 valve_on  output  1  irrigation valve drive.
REQ-010 alarm  output  1  alarm indicator for the display block.
REQ-011 level  output  2  filtered level code: 0 empty, 1 low, 2 mid, 3 high.
REQ-012 state  output  2  FSM state code: 0 IDLE, 1 FILL, 2 IRRIGATE, 3 FAULT.

Function
REQ-013 Each probe passes through a 2-flop synchronizer before any other use.
REQ-014 Valid {a,m,b} combinations: 000->0, 001->1, 011->2, 111->3; every other combination is inconsistent.
REQ-015 Filtered level updates only from a valid combination; level holds its value while the combination is inconsistent.
REQ-016 An inconsistent combination, after filtering, forces FAULT on the next edge from any state; this has priority over every other transition.
REQ-017 IDLE: level<=1 -> FILL; else irr_req=1 and level>=2 -> IRRIGATE; else stay.
REQ-018 FILL: level==3 -> IDLE; timeout reached -> FAULT.
REQ-019 IRRIGATE: irr_req=0 -> IDLE; level<=1 -> IDLE; FILL follows on the next edge.
REQ-020 FAULT: fault_clr=1 with a consistent combination -> IDLE; fault_clr with an inconsistent combination is ignored.
REQ-021 Timeout counter: cleared on entering FILL and on every level increase; counts otherwise while in FILL; reaching FILL_TIMEOUT-1 triggers FAULT; width $clog2(FILL_TIMEOUT).
REQ-022 Outputs are registered and decoded from the next state:
  - pump_on=1 only in FILL.
  - valve_on=1 only in IRRIGATE.
  - pump_on and valve_on are never 1 together.
REQ-023 alarm=1 when state is FAULT or level==0.
REQ-024 Latency from a stable probe change to the level update is 2 (synchronizer) + DEBOUNCE_CYCLES cycles; state and drive outputs follow 1 cycle later.

Reset
REQ-025 rst_n=0 immediately clears all outputs: pump_on=0, valve_on=0, level=0, state=IDLE.
REQ-026 rst_n=0 also clears the synchronizers, debounce counters and timeout counter.
REQ-027 alarm is 0 during reset, overriding REQ-023.
REQ-028 Reset asserted mid-FILL or mid-IRRIGATE de-energizes the pump and valve within the same cycle, without waiting for a clock edge.
REQ-029 After reset release, the first transition occurs only once the filtered level is valid.

Configuration
REQ-030 Macro NIVEL_DEBOUNCE_EN defined: per-probe stability filter as in REQ-001 is compiled in.
REQ-031 NIVEL_DEBOUNCE_EN undefined: filter removed, synchronizer outputs feed level directly, latency = 2 cycles, DEBOUNCE_CYCLES ignored.

Structure
REQ-032 Shared package holds:
  - the state enum (IDLE/FILL/IRRIGATE/FAULT);
  - the level code constants;
  - the valid-combination decode function.
REQ-033 One sub-module, filtro_sensor (2-flop synchronizer plus optional debounce), is instantiated once per probe.

Verification
REQ-034 Reset then probes 000 -> level=0, alarm=1, FILL and pump_on=1 by cycle 2+DEBOUNCE_CYCLES+1.
REQ-035 In FILL, probes step 001, 011, 111 -> level 1, 2, 3; IDLE with pump_on=0 after level 3.
REQ-036 Level 2, irr_req=1 -> IRRIGATE, valve_on=1; drop to 001 -> IDLE then FILL; valve_on and pump_on never overlap.
REQ-037 FILL_TIMEOUT=16, probes stuck at 001 -> FAULT after 16 cycles; fault_clr with 001 -> IDLE then FILL.
REQ-038 Probes 101 held in IRRIGATE -> FAULT and valve_on=0; fault_clr ignored while 101 is held.
REQ-039 1-cycle probe glitch with NIVEL_DEBOUNCE_EN defined -> no level change; rst_n asserted mid-FILL -> pump_on=0 at once.
